// File: rtl/sos_blinker.sv
// Morse "SOS" LED blinker: one frame of 34 Morse units, repeated forever.
// UNIT_CYCLES sets the length of one Morse unit in clk cycles.
//
// state      | meaning
// RESET_HOLD | held in reset, led off; next edge starts the frame
// MARK       | led on for 1 unit (S) or 3 units (O)
// SYM_GAP    | 1 unit off between symbols of one letter
// LETTER_GAP | 3 units off between letters
// WORD_GAP   | 7 units off before the frame wraps
module sos_blinker #(
  parameter int unsigned UNIT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic led
);

  localparam int unsigned TW      = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES + 1) : 1;
  localparam int unsigned UNIT_M1 = UNIT_CYCLES - 1;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    MARK       = 3'd1,
    SYM_GAP    = 3'd2,
    LETTER_GAP = 3'd3,
    WORD_GAP   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [2:0]    unit, unit_n;
  logic [1:0]    letter, letter_n;
  logic [1:0]    sym, sym_n;
  logic          led_n;
  logic [2:0]    len;
  logic          unit_done;
  logic          state_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RESET_HOLD;
      tick   <= '0;
      unit   <= '0;
      letter <= '0;
      sym    <= '0;
      led    <= 1'b0;
    end else begin
      state  <= state_n;
      tick   <= tick_n;
      unit   <= unit_n;
      letter <= letter_n;
      sym    <= sym_n;
      led    <= led_n;
    end
  end

  always_comb begin
    len = 3'd1;
    case (state)
      MARK:       len = (letter == 2'd1) ? 3'd3 : 3'd1;
      SYM_GAP:    len = 3'd1;
      LETTER_GAP: len = 3'd3;
      WORD_GAP:   len = 3'd7;
      default:    len = 3'd1;
    endcase
  end

  assign unit_done  = (tick == TW'(UNIT_M1));
  assign state_done = unit_done && (unit == len - 3'd1);

  always_comb begin
    state_n  = state;
    tick_n   = tick;
    unit_n   = unit;
    letter_n = letter;
    sym_n    = sym;
    case (state)
      RESET_HOLD: begin
        state_n  = MARK;
        tick_n   = '0;
        unit_n   = '0;
        letter_n = '0;
        sym_n    = '0;
      end
      MARK, SYM_GAP, LETTER_GAP, WORD_GAP: begin
        if (!unit_done) begin
          tick_n = tick + TW'(1);
        end else if (!state_done) begin
          tick_n = '0;
          unit_n = unit + 3'd1;
        end else begin
          tick_n = '0;
          unit_n = '0;
          case (state)
            MARK: begin
              if (sym < 2'd2)         state_n = SYM_GAP;
              else if (letter < 2'd2) state_n = LETTER_GAP;
              else                    state_n = WORD_GAP;
            end
            SYM_GAP: begin
              state_n = MARK;
              sym_n   = sym + 2'd1;
            end
            LETTER_GAP: begin
              state_n  = MARK;
              letter_n = letter + 2'd1;
              sym_n    = '0;
            end
            default: begin
              state_n  = MARK;
              letter_n = '0;
              sym_n    = '0;
            end
          endcase
        end
      end
      // Unused encodings fall back to the reset-hold path.
      default: begin
        state_n  = RESET_HOLD;
        tick_n   = '0;
        unit_n   = '0;
        letter_n = '0;
        sym_n    = '0;
      end
    endcase
  end

  assign led_n = (state_n == MARK);

endmodule

// File: tb/tb_sos_blinker.sv
// Self-checking bench for sos_blinker: UNIT_CYCLES=4 and UNIT_CYCLES=1 instances
// compared each cycle against a unit-pattern model, plus table-driven run checks.
module tb_sos_blinker;

  logic clk;
  logic rst;
  logic led;
  logic led1;

  int checks;
  int failures;
  int pos;
  bit pat[34];

  typedef struct {
    logic led;
    int   cycles;
  } run_t;

  run_t runs[18];

  sos_blinker #(.UNIT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .led(led)
  );

  sos_blinker #(.UNIT_CYCLES(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .led(led1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: led=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // One clock with rst=r, then compare both instances against the model.
  task automatic step(input logic r);
    logic e4, e1;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      e4  = 1'b0;
      e1  = 1'b0;
      pos = 0;
    end else begin
      e4  = pat[(pos / 4) % 34];
      e1  = pat[pos % 34];
      pos = pos + 1;
    end
    check("model_u4", led, e4);
    check("model_u1", led1, e1);
  endtask

  task automatic run_frame_table(input string name);
    int highs;
    int total;
    highs = 0;
    total = 0;
    foreach (runs[k]) begin
      for (int c = 0; c < runs[k].cycles; c++) begin
        step(1'b0);
        check(name, led, runs[k].led);
        if (led) highs++;
        total++;
      end
    end
    checks++;
    if (highs != 60 || total != 136) begin
      failures++;
      $display("FAIL %s_frame_totals: high=%0d len=%0d expected high=60 len=136", name, highs, total);
    end
  endtask

  initial begin
    int unit_runs[18];
    int idx;
    logic on;
    logic [33:0] golden;

    checks   = 0;
    failures = 0;
    pos      = 0;
    rst      = 1'b1;

    // Frame as on/off unit runs, starting with a mark.
    unit_runs = '{1, 1, 1, 1, 1, 3, 3, 1, 3, 1, 3, 3, 1, 1, 1, 1, 1, 7};
    idx = 0;
    on  = 1'b1;
    foreach (unit_runs[k]) begin
      for (int u = 0; u < unit_runs[k]; u++) begin
        pat[idx] = on;
        idx++;
      end
      on = ~on;
    end

    runs = '{'{1'b1, 4}, '{1'b0, 4}, '{1'b1, 4}, '{1'b0, 4}, '{1'b1, 4}, '{1'b0, 12},
             '{1'b1, 12}, '{1'b0, 4}, '{1'b1, 12}, '{1'b0, 4}, '{1'b1, 12}, '{1'b0, 12},
             '{1'b1, 4}, '{1'b0, 4}, '{1'b1, 4}, '{1'b0, 4}, '{1'b1, 4}, '{1'b0, 28}};

    // Reset hold, release, three frames back to back.
    for (int i = 0; i < 5; i++) step(1'b1);
    for (int f = 0; f < 3; f++) run_frame_table("frame");

    // Single-cycle reset in the second dash of O, then a fresh frame.
    for (int i = 0; i < 5; i++) step(1'b1);
    while (pos < 52) step(1'b0);
    step(1'b1);
    check("reset_mid_dash", led, 1'b0);
    run_frame_table("restart");

    // UNIT_CYCLES=1 instance against the literal bit string.
    golden = 34'b1010100011101110111000101010000000;
    step(1'b1);
    for (int i = 0; i < 68; i++) begin
      step(1'b0);
      check("u1_string", led1, golden[33 - (i % 34)]);
    end

    // Long reset hold.
    for (int i = 0; i < 200; i++) begin
      step(1'b1);
      check("long_hold", led, 1'b0);
    end

    // Random reset pulses, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
